// File: rtl/pipe_buf.sv
// pipe_buf -- small FIFO-style pipeline buffer between two pipeline stages.
// Holds up to DEPTH payloads in arrival order. Outputs come straight from
// registers, so a payload is never visible in the cycle it is pushed.
// With DEPTH=1 this is an ordinary valid/allowin stage register.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset; clears pointers, count, storage
//   flush        drops every buffered entry and any payload offered this cycle
//   in_valid     upstream offers in_data
//   in_allowin   buffer takes the offered payload this cycle
//   in_data      upstream payload (WIDTH bits, not interpreted)
//   out_valid    head entry is valid
//   out_allowin  downstream takes the head entry this cycle
//   out_data     head entry payload
//   count        number of valid entries
module pipe_buf #(
  parameter  int WIDTH      = 64,
  parameter  int DEPTH      = 2,
  parameter  int PIPE_READY = 1,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_allowin,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_allowin,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic             push, pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  // A full buffer may still take a payload when the head leaves this same
  // cycle (PIPE_READY). Deliberately ignores flush so allowin never depends
  // on the redirect path; push/pop below are what flush gates.
  assign in_allowin = (count < FULL) | ((PIPE_READY != 0) & out_valid & out_allowin);

  assign push = in_valid & in_allowin & ~flush;
  assign pop  = out_valid & out_allowin & ~flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // Storage is left as-is; it is unreachable once count is zero.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      if (push & ~pop)      count <= count + 1'b1;
      else if (pop & ~push) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_buf.sv
// Bench for pipe_buf: four configurations share one stimulus stream.
//   u0 DEPTH=2 PIPE_READY=1, u1 DEPTH=2 PIPE_READY=0,
//   u2 DEPTH=3 PIPE_READY=1, u3 DEPTH=1 PIPE_READY=1 (all WIDTH=32).
// A queue per instance models the buffer; every cycle all outputs are
// compared against it. A vector table pins exact values for u0/u1, and a
// hand sequence covers back-to-back streaming on u2/u3.
module tb_pipe_buf;

  typedef logic [31:0] q_t[$];

  typedef struct {
    logic iv; logic [31:0] id; logic oa; logic fl; logic rst;
    logic e_ov; logic [31:0] e_od; logic od_chk; int e_cnt; logic e_ia;
    int e1_cnt; logic e1_ia;
  } vec_t;

  logic        clk = 0;
  logic        rst_n, fl, iv, oa;
  logic [31:0] id;
  logic [3:0]  ov, ia;
  logic [31:0] od [4];
  logic [1:0]  c0, c1, c2;
  logic        c3;

  int checks = 0;
  int errors = 0;
  bit mdl_on = 0;
  q_t q0, q1, q2, q3;
  vec_t vt[26];

  always #5 clk = ~clk;

  pipe_buf #(.WIDTH(32), .DEPTH(2), .PIPE_READY(1)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(fl), .in_valid(iv), .in_allowin(ia[0]),
    .in_data(id), .out_valid(ov[0]), .out_allowin(oa), .out_data(od[0]), .count(c0));
  pipe_buf #(.WIDTH(32), .DEPTH(2), .PIPE_READY(0)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(fl), .in_valid(iv), .in_allowin(ia[1]),
    .in_data(id), .out_valid(ov[1]), .out_allowin(oa), .out_data(od[1]), .count(c1));
  pipe_buf #(.WIDTH(32), .DEPTH(3), .PIPE_READY(1)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(fl), .in_valid(iv), .in_allowin(ia[2]),
    .in_data(id), .out_valid(ov[2]), .out_allowin(oa), .out_data(od[2]), .count(c2));
  pipe_buf #(.WIDTH(32), .DEPTH(1), .PIPE_READY(1)) u3 (
    .clk(clk), .rst_n(rst_n), .flush(fl), .in_valid(iv), .in_allowin(ia[3]),
    .in_data(id), .out_valid(ov[3]), .out_allowin(oa), .out_data(od[3]), .count(c3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Compare one instance against its queue, then advance the queue by the
  // inputs applied this cycle.
  task automatic mdl(input string nm, input int depth, input bit pr,
                     input logic dov, input logic [31:0] dod, input int dcnt,
                     input logic dia, input q_t qi, output q_t qo);
    int  n = qi.size();
    bit  e_ia = (n < depth) || (pr && n != 0 && oa);
    if (mdl_on) begin
      chk({nm, " out_valid"}, {31'b0, dov}, {31'b0, n != 0});
      chk({nm, " count"}, dcnt, n);
      chk({nm, " in_allowin"}, {31'b0, dia}, {31'b0, e_ia});
      if (n != 0) chk({nm, " out_data"}, dod, qi[0]);
    end
    qo = qi;
    if (!rst_n || fl) qo.delete();
    else begin
      if (n != 0 && oa) void'(qo.pop_front());
      if (iv && e_ia) qo.push_back(id);
    end
  endtask

  // Called at the negedge with inputs stable; returns #1 after the next posedge.
  task automatic step();
    mdl("d2p1", 2, 1'b1, ov[0], od[0], int'(c0), ia[0], q0, q0);
    mdl("d2p0", 2, 1'b0, ov[1], od[1], int'(c1), ia[1], q1, q1);
    mdl("d3p1", 3, 1'b1, ov[2], od[2], int'(c2), ia[2], q2, q2);
    mdl("d1p1", 1, 1'b1, ov[3], od[3], int'(c3), ia[3], q3, q3);
    if (!rst_n) mdl_on = 1;
    @(posedge clk); #1;
  endtask

  function automatic vec_t mk(logic v, logic [31:0] d, logic o, logic f, logic r,
                              logic eov, logic [31:0] eod, logic odc, int ecnt,
                              logic eia, int e1c, logic e1i);
    vec_t t;
    t.iv = v; t.id = d; t.oa = o; t.fl = f; t.rst = r;
    t.e_ov = eov; t.e_od = eod; t.od_chk = odc; t.e_cnt = ecnt; t.e_ia = eia;
    t.e1_cnt = e1c; t.e1_ia = e1i;
    return t;
  endfunction

  initial begin
    //           iv  data  oa fl rst  ov  od  odc cnt ia  u1cnt u1ia
    vt[0]  = mk(0, 0,    0, 0, 1,  0, 0,    1, 0, 1,  0, 1); // reset state
    vt[1]  = mk(1, 'hA,  0, 0, 1,  0, 0,    1, 0, 1,  0, 1);
    vt[2]  = mk(1, 'hB,  0, 0, 1,  1, 'hA,  1, 1, 1,  1, 1);
    vt[3]  = mk(0, 0,    0, 0, 1,  1, 'hA,  1, 2, 0,  2, 0); // full
    vt[4]  = mk(1, 'hC,  0, 0, 1,  1, 'hA,  1, 2, 0,  2, 0); // blocked offer
    vt[5]  = mk(0, 0,    1, 0, 1,  1, 'hA,  1, 2, 1,  2, 0);
    vt[6]  = mk(0, 0,    1, 0, 1,  1, 'hB,  1, 1, 1,  1, 1);
    vt[7]  = mk(0, 0,    0, 0, 1,  0, 0,    0, 0, 1,  0, 1);
    vt[8]  = mk(1, 'hA,  0, 0, 1,  0, 0,    0, 0, 1,  0, 1);
    vt[9]  = mk(1, 'hB,  0, 0, 1,  1, 'hA,  1, 1, 1,  1, 1);
    vt[10] = mk(1, 'hC,  1, 0, 1,  1, 'hA,  1, 2, 1,  2, 0); // push+pop when full
    vt[11] = mk(0, 0,    1, 0, 1,  1, 'hB,  1, 2, 1,  1, 1);
    vt[12] = mk(0, 0,    1, 0, 1,  1, 'hC,  1, 1, 1,  0, 1);
    vt[13] = mk(0, 0,    0, 0, 1,  0, 0,    0, 0, 1,  0, 1);
    vt[14] = mk(1, 1,    0, 0, 1,  0, 0,    0, 0, 1,  0, 1);
    vt[15] = mk(1, 2,    0, 0, 1,  1, 1,    1, 1, 1,  1, 1);
    vt[16] = mk(1, 'hD,  1, 1, 1,  1, 1,    1, 2, 1,  2, 0); // flush
    vt[17] = mk(0, 0,    0, 0, 1,  0, 0,    0, 0, 1,  0, 1);
    vt[18] = mk(0, 0,    1, 0, 1,  0, 0,    0, 0, 1,  0, 1);
    vt[19] = mk(1, 3,    0, 0, 1,  0, 0,    0, 0, 1,  0, 1);
    vt[20] = mk(1, 4,    0, 0, 1,  1, 3,    1, 1, 1,  1, 1);
    vt[21] = mk(0, 0,    1, 0, 0,  1, 3,    1, 2, 1,  2, 0); // reset mid-stream
    vt[22] = mk(1, 5,    0, 0, 1,  0, 0,    1, 0, 1,  0, 1); // storage cleared
    vt[23] = mk(0, 0,    0, 0, 1,  1, 5,    1, 1, 1,  1, 1);
    vt[24] = mk(0, 0,    1, 0, 1,  1, 5,    1, 1, 1,  1, 1);
    vt[25] = mk(0, 0,    0, 0, 1,  0, 0,    0, 0, 1,  0, 1);

    rst_n = 0; fl = 0; iv = 0; oa = 0; id = '0;
    @(posedge clk); #1;
    @(negedge clk); step();

    foreach (vt[i]) begin
      iv = vt[i].iv; id = vt[i].id; oa = vt[i].oa; fl = vt[i].fl; rst_n = vt[i].rst;
      @(negedge clk);
      chk($sformatf("vec%0d u0 out_valid", i), {31'b0, ov[0]}, {31'b0, vt[i].e_ov});
      chk($sformatf("vec%0d u0 count", i), {30'b0, c0}, vt[i].e_cnt);
      chk($sformatf("vec%0d u0 in_allowin", i), {31'b0, ia[0]}, {31'b0, vt[i].e_ia});
      if (vt[i].od_chk) chk($sformatf("vec%0d u0 out_data", i), od[0], vt[i].e_od);
      chk($sformatf("vec%0d u1 count", i), {30'b0, c1}, vt[i].e1_cnt);
      chk($sformatf("vec%0d u1 in_allowin", i), {31'b0, ia[1]}, {31'b0, vt[i].e1_ia});
      step();
    end

    // Empty everything, then stream 1..10 with the consumer always ready.
    iv = 0; oa = 0; fl = 1; rst_n = 1;
    @(negedge clk); step();
    fl = 0;
    for (int i = 0; i <= 10; i++) begin
      iv = (i < 10); id = i + 1; oa = 1;
      @(negedge clk);
      if (i == 0) begin
        chk("stream u2 first out_valid", {31'b0, ov[2]}, 32'd0);
        chk("stream u3 first out_valid", {31'b0, ov[3]}, 32'd0);
      end else begin
        chk($sformatf("stream u2 out_data %0d", i), od[2], i);
        chk($sformatf("stream u2 count %0d", i), {30'b0, c2}, 1);
        chk($sformatf("stream u3 out_data %0d", i), od[3], i);
        chk($sformatf("stream u3 out_valid %0d", i), {31'b0, ov[3]}, 32'd1);
        chk($sformatf("stream u3 in_allowin %0d", i), {31'b0, ia[3]}, 32'd1);
      end
      step();
    end
    iv = 0; oa = 0;
    @(negedge clk);
    chk("stream u2 drained", {30'b0, c2}, 0);
    chk("stream u3 drained", {31'b0, c3}, 0);
    step();

    // Random traffic against the queue models.
    for (int n = 0; n < 3000; n++) begin
      iv    = $urandom_range(0, 3) != 0;
      oa    = $urandom_range(0, 2) != 0;
      fl    = $urandom_range(0, 29) == 0;
      rst_n = $urandom_range(0, 149) != 0;
      case ($urandom_range(0, 9))
        0:       id = '0;
        1:       id = '1;
        default: id = $urandom;
      endcase
      @(negedge clk);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
